// File: rtl/dtlb_refill_walker_if.sv
// Page-table read port and CAM write port of the DTLB refill walker.
// The walker drives through the master modport; memory and CAM sit on the slave side.
interface dtlb_refill_walker_if #(
    parameter int unsigned TLB_width   = 52,
    parameter int unsigned TLB_entries = 32,
    parameter int unsigned PA_width    = 34
);
    localparam int unsigned IDX_W = $clog2(TLB_entries);

    logic                 mem_req;
    logic [PA_width-1:0]  mem_addr;
    logic                 mem_ack;
    logic [31:0]          mem_rdata;
    logic                 we;
    logic [IDX_W-1:0]     write_addr;
    logic [TLB_width-1:0] write_data;

    modport master (
        output mem_req, mem_addr, we, write_addr, write_data,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, we, write_addr, write_data,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dtlb_refill_walker.sv
// Sv32 two-level page-table walker that refills the DTLB CAM round-robin
// and sequentially invalidates every CAM entry on a flush request.
module dtlb_refill_walker #(
    parameter int unsigned TLB_width   = 52,
    parameter int unsigned TLB_entries = 32,
    parameter int unsigned PA_width    = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss,
    input  logic [19:0]          vpn,
    input  logic                 dtlb_trans_off,
    input  logic [21:0]          satp_ppn,
    input  logic                 flush_req,
    dtlb_refill_walker_if.master bus,
    output logic                 walk_busy,
    output logic                 refill_done,
    output logic                 page_fault,
    output logic [19:0]          fault_vpn,
    output logic                 flush_done
);
    localparam int unsigned      IDX_W    = $clog2(TLB_entries);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_entries - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1_REQ = 3'd1,
        L0_REQ = 3'd2,
        FILL   = 3'd3,
        FAULT  = 3'd4,
        FLUSH  = 3'd5
    } state_t;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d, a, g, u, x, w, r, v;
    } pte_t;

    state_t               state_q, state_d;
    logic [19:0]          vpn_q, vpn_d;
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic [IDX_W-1:0]     flush_idx_q, flush_idx_d;
    logic                 mem_req_q, mem_req_d;
    logic [PA_width-1:0]  mem_addr_q, mem_addr_d;
    logic                 we_q, we_d;
    logic [IDX_W-1:0]     write_addr_q, write_addr_d;
    logic [TLB_width-1:0] write_data_q, write_data_d;
    logic                 walk_busy_q, walk_busy_d;
    logic                 refill_done_q, refill_done_d;
    logic                 page_fault_q, page_fault_d;
    logic [19:0]          fault_vpn_q, fault_vpn_d;
    logic                 flush_done_q, flush_done_d;

    pte_t pte;
    logic pte_bad;
    logic pte_leaf;

    // PTE decode is only meaningful in the cycle mem_ack is high.
    assign pte      = pte_t'(bus.mem_rdata);
    assign pte_bad  = !pte.v || (!pte.r && pte.w);
    assign pte_leaf = pte.r || pte.x;

    always_comb begin
        state_d       = state_q;
        vpn_d         = vpn_q;
        victim_d      = victim_q;
        flush_idx_d   = flush_idx_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        we_d          = 1'b0;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        refill_done_d = 1'b0;
        page_fault_d  = 1'b0;
        fault_vpn_d   = fault_vpn_q;
        flush_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Flush wins over a simultaneous miss; the CAM re-reports the miss.
                if (flush_req) begin
                    state_d      = FLUSH;
                    flush_idx_d  = '0;
                    we_d         = 1'b1;
                    write_addr_d = '0;
                    write_data_d = '0;
                end else if (miss && !dtlb_trans_off) begin
                    state_d    = L1_REQ;
                    vpn_d      = vpn;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {satp_ppn, vpn[19:10], 2'b00};
                end
            end
            L1_REQ: begin
                if (bus.mem_ack) begin
                    if (pte_bad || (pte_leaf && pte.ppn0 != 10'd0)) begin
                        state_d      = FAULT;
                        mem_req_d    = 1'b0;
                        page_fault_d = 1'b1;
                        fault_vpn_d  = vpn_q;
                    end else if (pte_leaf) begin
                        state_d       = FILL;
                        mem_req_d     = 1'b0;
                        we_d          = 1'b1;
                        write_addr_d  = victim_q;
                        write_data_d  = {vpn_q, pte.ppn1, vpn_q[9:0], pte[9:0]};
                        refill_done_d = 1'b1;
                    end else begin
                        state_d    = L0_REQ;
                        mem_addr_d = {pte.ppn1, pte.ppn0, vpn_q[9:0], 2'b00};
                    end
                end
            end
            L0_REQ: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pte_bad || !pte_leaf) begin
                        state_d      = FAULT;
                        page_fault_d = 1'b1;
                        fault_vpn_d  = vpn_q;
                    end else begin
                        state_d       = FILL;
                        we_d          = 1'b1;
                        write_addr_d  = victim_q;
                        write_data_d  = {vpn_q, pte.ppn1, pte.ppn0, pte[9:0]};
                        refill_done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                state_d  = IDLE;
                victim_d = victim_q + IDX_W'(1);
            end
            FAULT: begin
                state_d = IDLE;
            end
            FLUSH: begin
                if (flush_idx_q == LAST_IDX) begin
                    state_d      = IDLE;
                    victim_d     = '0;
                    flush_done_d = 1'b1;
                end else begin
                    flush_idx_d  = flush_idx_q + IDX_W'(1);
                    we_d         = 1'b1;
                    write_addr_d = flush_idx_q + IDX_W'(1);
                    write_data_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        walk_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            vpn_q         <= '0;
            victim_q      <= '0;
            flush_idx_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            we_q          <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            walk_busy_q   <= 1'b0;
            refill_done_q <= 1'b0;
            page_fault_q  <= 1'b0;
            fault_vpn_q   <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vpn_q         <= vpn_d;
            victim_q      <= victim_d;
            flush_idx_q   <= flush_idx_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            we_q          <= we_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            walk_busy_q   <= walk_busy_d;
            refill_done_q <= refill_done_d;
            page_fault_q  <= page_fault_d;
            fault_vpn_q   <= fault_vpn_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.we         = we_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign walk_busy      = walk_busy_q;
    assign refill_done    = refill_done_q;
    assign page_fault     = page_fault_q;
    assign fault_vpn      = fault_vpn_q;
    assign flush_done     = flush_done_q;
endmodule

// File: tb/tb_dtlb_refill_walker.sv
// Directed bench for dtlb_refill_walker: vector table of walks plus flush,
// round-robin wrap, translation-off and reset-mid-walk sequences.
module tb_dtlb_refill_walker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss = 1'b0;
    logic [19:0] vpn = '0;
    logic        dtlb_trans_off = 1'b0;
    logic [21:0] satp_ppn = 22'h000001;
    logic        flush_req = 1'b0;
    logic        walk_busy, refill_done, page_fault, flush_done;
    logic [19:0] fault_vpn;

    dtlb_refill_walker_if bus ();

    dtlb_refill_walker dut (
        .clk            (clk),
        .rst            (rst),
        .miss           (miss),
        .vpn            (vpn),
        .dtlb_trans_off (dtlb_trans_off),
        .satp_ppn       (satp_ppn),
        .flush_req      (flush_req),
        .bus            (bus),
        .walk_busy      (walk_busy),
        .refill_done    (refill_done),
        .page_fault     (page_fault),
        .fault_vpn      (fault_vpn),
        .flush_done     (flush_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] vpn;
        logic [33:0] l1a;
        logic [31:0] l1;
        bit          two;
        logic [33:0] l0a;
        logic [31:0] l0;
        bit          fault;
        int          lat;
        logic [51:0] wdata;
    } vec_t;

    // Page-table memory model: ack one cycle after each new request.
    logic [31:0] mem_tbl [logic [33:0]];
    bit ack_en   = 1'b1;
    bit late_ack = 1'b0;
    bit waited   = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            waited        = 1'b0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            waited      = bus.mem_req;
        end else if (late_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h0000000F;
        end else if (bus.mem_req && ack_en) begin
            if (waited) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_tbl.exists(bus.mem_addr) ? mem_tbl[bus.mem_addr] : 32'h0;
            end else begin
                waited = 1'b1;
            end
        end else begin
            waited = 1'b0;
        end
    end

    int we_cnt = 0, req_cnt = 0, pf_cnt = 0, excl_viol = 0;
    always @(negedge clk) begin
        if (bus.we)      we_cnt++;
        if (bus.mem_req) req_cnt++;
        if (page_fault)  pf_cnt++;
        if ((int'(refill_done) + int'(page_fault) + int'(flush_done)) > 1 ||
            (bus.we && (page_fault || flush_done)))
            excl_viol++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [4:0] exp_victim = '0;

    task automatic load_mem(input vec_t v);
        mem_tbl.delete();
        mem_tbl[v.l1a] = v.l1;
        if (v.two) mem_tbl[v.l0a] = v.l0;
    endtask

    task automatic pulse_miss(input logic [19:0] v);
        @(posedge clk); #1;
        miss = 1'b1;
        vpn  = v;
        @(posedge clk); #1;
        miss = 1'b0;
        vpn  = '0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int we0 = we_cnt;
        int n;
        bit seen = 1'b0;
        load_mem(v);
        pulse_miss(v.vpn);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (refill_done || page_fault) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 64'(seen), 64'(1));
        chk({tag, "_latency"}, 64'(n), 64'(v.lat));
        chk({tag, "_busy_in_pulse"}, 64'(walk_busy), 64'(1));
        if (v.fault) begin
            chk({tag, "_page_fault"}, 64'(page_fault), 64'(1));
            chk({tag, "_fault_vpn"}, 64'(fault_vpn), 64'(v.vpn));
        end else begin
            chk({tag, "_we"}, 64'(bus.we), 64'(1));
            chk({tag, "_write_addr"}, 64'(bus.write_addr), 64'(exp_victim));
            chk({tag, "_write_data"}, 64'(bus.write_data), 64'(v.wdata));
            exp_victim = exp_victim + 5'd1;
        end
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(walk_busy), 64'(0));
        chk({tag, "_we_count"}, 64'(we_cnt - we0), 64'(v.fault ? 0 : 1));
    endtask

    vec_t vt[10];

    initial begin
        bit ok;
        int we0, req0, pf0;
        vec_t v;

        vt[0] = '{20'h12345, 34'h1120, 32'h00002001, 1'b1, 34'h8D14, 32'h0ABCD0CF, 1'b0, 5,
                  {20'h12345, 22'h02AF34, 10'h0CF}};
        vt[1] = '{20'h3FF7A, 34'h13FC, 32'h1230000F, 1'b0, 34'h0, 32'h0, 1'b0, 3,
                  {20'h3FF7A, 12'h123, 10'h37A, 10'h00F}};
        vt[2] = '{20'h3FF7A, 34'h13FC, 32'h1230040F, 1'b0, 34'h0, 32'h0, 1'b1, 3, 52'h0};
        vt[3] = '{20'h12345, 34'h1120, 32'h00002001, 1'b1, 34'h8D14, 32'h0ABCD0CE, 1'b1, 5, 52'h0};
        vt[4] = '{20'h12345, 34'h1120, 32'h00002001, 1'b1, 34'h8D14, 32'h00000005, 1'b1, 5, 52'h0};
        vt[5] = '{20'h12345, 34'h1120, 32'h00002001, 1'b1, 34'h8D14, 32'h00000001, 1'b1, 5, 52'h0};
        vt[6] = '{20'h00000, 34'h1000, 32'h00004001, 1'b1, 34'h10000, 32'hFFFFFC0B, 1'b0, 5,
                  {20'h00000, 22'h3FFFFF, 10'h00B}};
        vt[7] = '{20'h00401, 34'h1004, 32'hABC00003, 1'b0, 34'h0, 32'h0, 1'b0, 3,
                  {20'h00401, 12'hABC, 10'h001, 10'h003}};
        vt[8] = '{20'h00401, 34'h1004, 32'h00000005, 1'b0, 34'h0, 32'h0, 1'b1, 3, 52'h0};
        vt[9] = '{20'h00401, 34'h1004, 32'h00000000, 1'b0, 34'h0, 32'h0, 1'b1, 3, 52'h0};

        // Reset state
        #2;
        chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
        chk("rst_we", 64'(bus.we), 64'(0));
        chk("rst_write_addr", 64'(bus.write_addr), 64'(0));
        chk("rst_write_data", 64'(bus.write_data), 64'(0));
        chk("rst_walk_busy", 64'(walk_busy), 64'(0));
        chk("rst_pulses", 64'({refill_done, page_fault, flush_done}), 64'(0));
        chk("rst_fault_vpn", 64'(fault_vpn), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Translation off: miss ignored
        req0 = req_cnt;
        dtlb_trans_off = 1'b1;
        pulse_miss(20'h12345);
        repeat (6) @(negedge clk);
        dtlb_trans_off = 1'b0;
        chk("transoff_no_req", 64'(req_cnt - req0), 64'(0));
        chk("transoff_busy", 64'(walk_busy), 64'(0));

        // Flush raised during L0_REQ: walk finishes, then 32 clears
        load_mem(vt[0]);
        pulse_miss(vt[0].vpn);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_addr == 34'h8D14) begin ok = 1'b1; break; end
        end
        chk("flushwalk_l0_seen", 64'(ok), 64'(1));
        flush_req = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (refill_done) begin ok = 1'b1; break; end
        end
        chk("flushwalk_fill", 64'(ok), 64'(1));
        chk("flushwalk_fill_addr", 64'(bus.write_addr), 64'(exp_victim));
        chk("flushwalk_fill_data", 64'(bus.write_data), 64'(vt[0].wdata));
        @(negedge clk);
        chk("flushwalk_idle_gap_we", 64'(bus.we), 64'(0));
        begin
            int bad = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (!bus.we || bus.write_data != 52'h0 || bus.write_addr != 5'(i) || flush_done) bad++;
            end
            chk("flush_writes_bad", 64'(bad), 64'(0));
        end
        @(negedge clk);
        chk("flush_done_pulse", 64'(flush_done), 64'(1));
        chk("flush_done_no_we", 64'(bus.we), 64'(0));
        flush_req = 1'b0;
        exp_victim = '0;
        run_vec("post_flush", vt[7]);

        // Flush and miss in the same IDLE cycle: no walk
        req0 = req_cnt;
        we0  = we_cnt;
        load_mem(vt[0]);
        @(posedge clk); #1;
        flush_req = 1'b1;
        miss      = 1'b1;
        vpn       = vt[0].vpn;
        @(posedge clk); #1;
        miss = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (flush_done) begin ok = 1'b1; break; end
        end
        flush_req = 1'b0;
        chk("flushmiss_done", 64'(ok), 64'(1));
        repeat (6) @(negedge clk);
        chk("flushmiss_no_req", 64'(req_cnt - req0), 64'(0));
        chk("flushmiss_writes", 64'(we_cnt - we0), 64'(32));
        exp_victim = '0;

        // Round-robin wrap over 33 superpage fills
        for (int i = 0; i < 33; i++) begin
            v = vt[7];
            v.vpn   = {10'h001, 10'(i)};
            v.wdata = {10'h001, 10'(i), 12'hABC, 10'(i), 10'h003};
            run_vec($sformatf("rr%0d", i), v);
        end

        // Reset mid-walk with a late ack afterwards
        ack_en = 1'b0;
        load_mem(vt[0]);
        pulse_miss(vt[0].vpn);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.mem_req) begin ok = 1'b1; break; end
        end
        chk("rstwalk_req_seen", 64'(ok), 64'(1));
        we0 = we_cnt;
        pf0 = pf_cnt;
        rst = 1'b0;
        #1;
        chk("rstwalk_mem_req_drop", 64'(bus.mem_req), 64'(0));
        chk("rstwalk_busy", 64'(walk_busy), 64'(0));
        @(posedge clk); #2;
        rst      = 1'b1;
        late_ack = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        late_ack = 1'b0;
        ack_en   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstwalk_no_we", 64'(we_cnt - we0), 64'(0));
        chk("rstwalk_no_fault", 64'(pf_cnt - pf0), 64'(0));
        chk("rstwalk_busy_after", 64'(walk_busy), 64'(0));
        exp_victim = '0;
        run_vec("post_reset", vt[1]);

        chk("pulse_exclusivity", 64'(excl_viol), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
